queue_arbiter: RTL and testbench
================================

QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of producer requesters sharing the queue write port.
REQ-002 Parameter WIDTH, default 32: data word width, equal to queue wr_val/rd_val width.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester word available.
REQ-006 req_data  in  NREQ*WIDTH  per-requester word; slice i is bits [i*WIDTH +: WIDTH].
REQ-007 req_ready  out  NREQ  one-hot grant; a word transfers when valid&ready.
REQ-008 q_push / q_pop / q_peek  out  1 each  queue control strobes.
REQ-009 q_wr_val  out  WIDTH  queue write data.
REQ-010 q_rd_val  in  WIDTH  queue read data, valid the cycle after q_peek.
REQ-011 q_empty / q_full  in  1 each  queue status.
REQ-012 out_valid / out_ready / out_data  out / in / out  1 / 1 / WIDTH  consumer stream.
REQ-013 acc_cnt  out  NREQ*16  per-requester accepted-word counters.

Function
REQ-014 Write arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NREQ.
REQ-015 At most one req_ready bit SHALL be high per cycle, and only to a requester with req_valid=1.
REQ-016 req_ready SHALL be all-zero whenever q_full=1.
REQ-017 q_push SHALL equal OR(req_ready) combinationally, and q_wr_val SHALL be the granted slice, giving zero-cycle write latency.
REQ-018 q_wr_val SHALL be 0 when no grant is given.
REQ-019 On a grant to index g, rr_ptr SHALL become (g+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-020 acc_cnt[g] SHALL increment by 1 on each grant to g and wrap from 16'hFFFF to 0.
REQ-021 The read FSM SHALL have three states: IDLE, PEEK, HOLD.
REQ-022 IDLE -> PEEK when q_empty=0; q_peek SHALL be asserted for exactly that one cycle (the PEEK state).
REQ-023 PEEK -> HOLD unconditionally; in that transition out_data SHALL be registered from q_rd_val.
REQ-024 In HOLD, out_valid SHALL be 1 and out_data SHALL be held stable until out_ready=1.
REQ-025 HOLD with out_ready=1: q_pop SHALL be pulsed for one cycle; next state SHALL be PEEK if q_empty=0 after this pop would leave data, otherwise IDLE.
REQ-026 The HOLD->PEEK decision SHALL use q_empty sampled in the pop cycle, treating a single remaining entry as empty unless q_push is also asserted in that cycle.
REQ-027 To support this, the block SHALL track queue occupancy internally with a counter of width clog2(depth)+1, updated by push and pop together (simultaneous push and pop leaves it unchanged).
REQ-028 Simultaneous write grant and read pop in the same cycle SHALL be permitted.
REQ-029 q_pop and q_peek SHALL never be asserted in the same cycle.
REQ-030 q_pop SHALL never be asserted while q_empty=1.

Reset
REQ-031 On rst_n=0, all of the following SHALL clear asynchronously: FSM to IDLE, rr_ptr=0, acc_cnt=0, occupancy=0, out_valid=0, out_data=0, q_pop=0, q_peek=0.
REQ-032 req_ready, q_push and q_wr_val SHALL be 0 while rst_n=0.
REQ-033 A word held in HOLD at reset SHALL be dropped without a pop, i.e. it remains in the queue.

Structure
REQ-034 A shared package SHALL hold the read-FSM state enum, WIDTH default, NREQ default, and counter width constant.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req vector, pointer, enable; output: one-hot grant).

Verification
REQ-036 Reset then all four req_valid=1 with data 'h1A2B+i, q_full=0 -> grants in order 0,1,2,3,0, and q_wr_val matches each grant.
REQ-037 q_full=1 with req_valid=4'b1111 -> req_ready=0, q_push=0, and rr_ptr unchanged.
REQ-038 Queue holds 'h3C4D -> q_peek on cycle 1, then out_valid=1 with out_data='h3C4D; out_ready held low for 5 cycles -> data stable and no q_pop.
REQ-039 out_ready=1 in the same cycle as a grant from requester 2 -> q_pop and q_push both pulse, and occupancy is unchanged.
REQ-040 With acc_cnt[1]=16'hFFFF, grant requester 1 -> acc_cnt[1]=0.
REQ-041 rst_n dropped mid-HOLD -> out_valid=0 immediately; after release, with q_empty=0, the FSM peeks the same entry again.

Source files
------------

// File: rtl/queue_arbiter_pkg.sv
// Shared types and default sizes for the queue arbiter block.
package queue_arbiter_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEEK = 2'd1,
    HOLD = 2'd2
  } rd_state_e;

  // Pointer width that stays legal for a single requester.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/queue_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first requester at or after i_ptr, wrapping modulo NREQ.
module rr_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned PTR_W = ptr_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [NREQ-1:0]  o_grant
);

  localparam int unsigned SW = PTR_W + 1;

  logic [SW-1:0]    w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sum = SW'(i_ptr) + SW'(i);
      if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
      w_idx = w_sum[PTR_W-1:0];
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Multi-producer queue front end: round-robin write arbitration, peek/hold/pop
// read FSM feeding a valid/ready consumer, and per-requester accept counters.
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  q_push,
  output logic                  q_pop,
  output logic                  q_peek,
  output logic [WIDTH-1:0]      q_wr_val,
  input  logic [WIDTH-1:0]      q_rd_val,
  input  logic                  q_empty,
  input  logic                  q_full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [NREQ*CNT_W-1:0] acc_cnt
);

  localparam int unsigned PTR_W = ptr_w(NREQ);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [NREQ-1:0]  w_grant;
  logic [PTR_W-1:0] w_gidx;
  logic             w_push;
  logic [CNT_W-1:0] r_acc [NREQ];
  logic [OCC_W-1:0] r_occ;
  rd_state_e        r_state;
  rd_state_e        w_state_nxt;
  logic             w_pop;
  logic             w_peek;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (~q_full),
    .o_grant (w_grant)
  );

  // Outputs forced quiet while reset is held; flops are in reset then anyway.
  always_comb begin
    req_ready = w_grant & {NREQ{rst_n}};
    q_push    = |req_ready;
    q_wr_val  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) q_wr_val = q_wr_val | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_push = |w_grant;
    w_gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_push) begin
      r_rr_ptr <= (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) r_acc[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_grant[i]) r_acc[i] <= r_acc[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    acc_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) acc_cnt[i*CNT_W +: CNT_W] = r_acc[i];
  end

  // Occupancy mirror, clamped so a stale queue after reset cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   if (r_occ != OCC_W'(DEPTH)) r_occ <= r_occ + OCC_W'(1);
        2'b01:   if (r_occ != '0) r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // After a pop, re-peek only if something besides the popped word remains.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!q_empty) w_state_nxt = PEEK;
      PEEK:    w_state_nxt = HOLD;
      HOLD: begin
        if (w_pop) w_state_nxt = (r_occ > OCC_W'(1) || w_push) ? PEEK : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_peek = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      PEEK:    w_peek = 1'b1;
      HOLD:    w_pop  = out_ready & ~q_empty;
      default: ;
    endcase
  end

  assign q_peek = w_peek;
  assign q_pop  = w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == PEEK) begin
      r_out_valid <= 1'b1;
      r_out_data  <= q_rd_val;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter with a small behavioural queue model.
module tb_queue_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         q_push, q_pop, q_peek;
  logic [31:0]  q_wr_val, q_rd_val;
  logic         q_empty, q_full;
  logic         out_valid, out_ready;
  logic [31:0]  out_data;
  logic [63:0]  acc_cnt;

  logic         force_full;
  logic         sink;
  logic         model_clr;
  logic [31:0]  mem [16];
  logic [3:0]   m_head;
  logic [4:0]   m_cnt;

  int n_checks;
  int n_err;

  typedef struct {
    logic [3:0]  rv;
    logic        full;
    logic [3:0]  exp_rdy;
    logic [31:0] exp_wr;
  } vec_t;

  vec_t tbl [13];

  queue_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q_push    (q_push),
    .q_pop     (q_pop),
    .q_peek    (q_peek),
    .q_wr_val  (q_wr_val),
    .q_rd_val  (q_rd_val),
    .q_empty   (q_empty),
    .q_full    (q_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue model; in sink mode it swallows pushes and always reads empty.
  always @(posedge clk) begin
    if (model_clr) begin
      m_head <= 4'd0;
      m_cnt  <= 5'd0;
    end else if (!sink) begin
      if (q_pop)  m_head <= m_head + 4'd1;
      if (q_push) mem[m_head + m_cnt[3:0]] <= q_wr_val;
      m_cnt <= m_cnt + 5'(q_push) - 5'(q_pop);
    end
  end

  assign q_empty  = sink || (m_cnt == 5'd0);
  assign q_full   = force_full || (m_cnt >= 5'd16);
  assign q_rd_val = mem[m_head];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    model_clr = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    model_clr = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    model_clr  = 1'b1;
    sink       = 1'b0;
    force_full = 1'b0;
    out_ready  = 1'b0;
    req_valid  = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h1A2B + 32'(i);

    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 32'h1A2B};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 32'h1A2C};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 32'h1A2D};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 32'h1A2E};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 32'h1A2B};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 32'h0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0000, 32'h0};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 32'h1A2C};
    tbl[8]  = '{4'b0001, 1'b0, 4'b0001, 32'h1A2B};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 32'h0};
    tbl[10] = '{4'b1001, 1'b0, 4'b1000, 32'h1A2E};
    tbl[11] = '{4'b0110, 1'b0, 4'b0010, 32'h1A2C};
    tbl[12] = '{4'b0110, 1'b0, 4'b0100, 32'h1A2D};

    // Reset state with every requester asserting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_q_push",    64'(q_push),    64'h0);
    chk("rst_q_wr_val",  64'(q_wr_val),  64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_q_peek",    64'(q_peek),    64'h0);
    chk("rst_q_pop",     64'(q_pop),     64'h0);
    chk("rst_acc_cnt",   acc_cnt,        64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_clr = 1'b0;
    req_valid = 4'b0000;

    // Round-robin order, full back-pressure, pointer hold and wrap
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_valid  = tbl[i].rv;
      force_full = tbl[i].full;
      #1;
      chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_q_push", i),    64'(q_push),    64'(tbl[i].exp_rdy != 4'b0000));
      chk($sformatf("vec%0d_q_wr_val", i),  64'(q_wr_val),  64'(tbl[i].exp_wr));
    end
    @(negedge clk);
    req_valid  = 4'b0000;
    force_full = 1'b0;
    #1;
    chk("acc_after_table", acc_cnt, 64'h0002_0002_0003_0003);

    // Peek, hold with consumer stalled, then pop alongside a push
    do_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[31:0] = 32'h3C4D;
    #1;
    chk("hold_push", 64'(q_push), 64'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("hold_idle_no_peek", 64'(q_peek), 64'h0);
    @(negedge clk);
    #1;
    chk("hold_peek", 64'(q_peek), 64'h1);
    chk("hold_peek_no_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d_valid", i), 64'(out_valid), 64'h1);
      chk($sformatf("stall%0d_data", i),  64'(out_data),  64'h3C4D);
      chk($sformatf("stall%0d_pop", i),   64'(q_pop),     64'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    req_valid = 4'b0100;
    req_data[95:64] = 32'h5E6F;
    #1;
    chk("both_pop",   64'(q_pop),     64'h1);
    chk("both_push",  64'(q_push),    64'h1);
    chk("both_ready", 64'(req_ready), 64'h4);
    chk("both_occ_before", 64'(dut.r_occ), 64'h1);
    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("both_occ_after", 64'(dut.r_occ), 64'h1);
    chk("repeek", 64'(q_peek), 64'h1);
    @(negedge clk);
    #1;
    chk("second_valid", 64'(out_valid), 64'h1);
    chk("second_data",  64'(out_data),  64'h5E6F);
    out_ready = 1'b1;
    #1;
    chk("last_pop",     64'(q_pop),  64'h1);
    chk("last_no_push", 64'(q_push), 64'h0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("drained_valid", 64'(out_valid), 64'h0);
    chk("drained_peek",  64'(q_peek),    64'h0);
    chk("drained_occ",   64'(dut.r_occ), 64'h0);

    // Accept counter wrap on requester 1
    do_reset();
    sink = 1'b1;
    @(negedge clk);
    req_valid = 4'b0010;
    repeat (65535) @(negedge clk);
    #1;
    chk("acc1_max",  64'(acc_cnt[31:16]), 64'hFFFF);
    chk("acc0_zero", 64'(acc_cnt[15:0]),  64'h0);
    @(negedge clk);
    #1;
    chk("acc1_wrap", 64'(acc_cnt[31:16]), 64'h0);
    req_valid = 4'b0000;
    sink      = 1'b0;

    // Reset in HOLD drops the word without popping it
    do_reset();
    @(negedge clk);
    req_valid = 4'b1000;
    req_data[127:96] = 32'h7788;
    #1;
    chk("mid_push_ready", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("mid_peek", 64'(q_peek), 64'h1);
    @(negedge clk);
    #1;
    chk("mid_hold_valid", 64'(out_valid), 64'h1);
    chk("mid_hold_data",  64'(out_data),  64'h7788);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("mid_rst_valid",  64'(out_valid), 64'h0);
    chk("mid_rst_data",   64'(out_data),  64'h0);
    chk("mid_rst_ready",  64'(req_ready), 64'h0);
    chk("mid_rst_push",   64'(q_push),    64'h0);
    chk("mid_rst_wr_val", 64'(q_wr_val),  64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("post_rst_peek", 64'(q_peek), 64'h1);
    @(negedge clk);
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'h1);
    chk("post_rst_data",  64'(out_data),  64'h7788);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
